// File: rtl/ddr_maint_cmd_issuer_if.sv
// Maintenance handshake and DDR4 command-pin bundle between the controller and the issuer.
interface ddr_maint_cmd_issuer_if #(
  parameter int unsigned MRS_WIDTH = 18
);
  logic                 rw_proc;
  logic                 rw_active;
  logic                 refresh_rdy;
  logic                 mrs_update_rdy;
  logic [MRS_WIDTH-1:0] mrs_update_cmd;
  logic                 rw_idle;
  logic                 maint_busy;
  logic                 maint_cmd_valid;
  logic                 cs_n;
  logic                 act_n;
  logic                 ras_n;
  logic                 cas_n;
  logic                 we_n;
  logic [1:0]           bg;
  logic [1:0]           ba;
  logic [MRS_WIDTH-1:0] addr;
  logic                 req_overrun;

  modport slave (
    input  rw_proc, rw_active, refresh_rdy, mrs_update_rdy, mrs_update_cmd,
    output rw_idle, maint_busy, maint_cmd_valid, cs_n, act_n, ras_n, cas_n, we_n,
    output bg, ba, addr, req_overrun
  );

  modport master (
    output rw_proc, rw_active, refresh_rdy, mrs_update_rdy, mrs_update_cmd,
    input  rw_idle, maint_busy, maint_cmd_valid, cs_n, act_n, ras_n, cas_n, we_n,
    input  bg, ba, addr, req_overrun
  );
endinterface

// File: rtl/ddr_maint_cmd_issuer.sv
// DDR4 maintenance issuer: drains the RW path, then PREA + REF and/or MRS with tRP/tRFC/tMOD.
// Define DDR_MAINT_STATS_EN to add 16-bit wrapping REF/MRS issue counters.
module ddr_maint_cmd_issuer #(
  parameter int unsigned MRS_WIDTH = 18,
  parameter int unsigned T_RP      = 13,
  parameter int unsigned T_RFC     = 260,
  parameter int unsigned T_MOD     = 24,
  parameter int unsigned T_DRAIN   = 16
) (
  input  logic                  i_clock_t,
  input  logic                  i_reset,
  ddr_maint_cmd_issuer_if.slave io_bus
`ifdef DDR_MAINT_STATS_EN
  ,
  output logic [15:0]           o_ref_count,
  output logic [15:0]           o_mrs_count
`endif
);

  localparam int unsigned TMaxA  = (T_RP > T_MOD) ? T_RP : T_MOD;
  localparam int unsigned TMax   = (T_RFC > TMaxA) ? T_RFC : TMaxA;
  localparam int unsigned WaitW  = $clog2(TMax + 1);
  localparam int unsigned DrainW = $clog2(T_DRAIN + 1);

  // {cs_n, act_n, ras_n, cas_n, we_n}
  localparam logic [4:0] CmdDes  = 5'b11111;
  localparam logic [4:0] CmdPrea = 5'b01010;
  localparam logic [4:0] CmdRef  = 5'b01001;
  localparam logic [4:0] CmdMrs  = 5'b01000;

  localparam logic [MRS_WIDTH-1:0] PreaAddr = {{(MRS_WIDTH-11){1'b0}}, 1'b1, 10'd0};

  typedef enum logic [2:0] {
    StIdle,
    StPrea,
    StWaitRp,
    StRef,
    StWaitRfc,
    StMrs,
    StWaitMod
  } state_e;

  state_e               r_state;
  logic [WaitW-1:0]     r_wait;
  logic [DrainW-1:0]    r_drain;
  logic                 r_ref_pend;
  logic                 r_mrs_pend;
  logic [MRS_WIDTH-1:0] r_mrs_op;
  logic                 r_overrun;
  logic [4:0]           r_cmd;
  logic [MRS_WIDTH-1:0] r_addr;

  logic w_drained;
  logic w_ref_clr;
  logic w_mrs_clr;

  assign w_drained = (r_drain == DrainW'(T_DRAIN));
  assign w_ref_clr = (r_state == StRef);
  assign w_mrs_clr = (r_state == StMrs);

  // Drain counter: any RW activity restarts the quiet window.
  always_ff @(posedge i_clock_t) begin
    if (i_reset) begin
      r_drain <= '0;
    end else if (io_bus.rw_proc || io_bus.rw_active) begin
      r_drain <= '0;
    end else if (!w_drained) begin
      r_drain <= r_drain + DrainW'(1);
    end
  end

  // Request capture; a repeat pulse while pending is recorded but never replaces the request.
  always_ff @(posedge i_clock_t) begin
    if (i_reset) begin
      r_ref_pend <= 1'b0;
      r_mrs_pend <= 1'b0;
      r_mrs_op   <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_ref_pend <= io_bus.refresh_rdy | (r_ref_pend & ~w_ref_clr);
      r_mrs_pend <= io_bus.mrs_update_rdy | (r_mrs_pend & ~w_mrs_clr);
      if (io_bus.mrs_update_rdy && !r_mrs_pend) begin
        r_mrs_op <= io_bus.mrs_update_cmd;
      end
      if ((io_bus.refresh_rdy && r_ref_pend) || (io_bus.mrs_update_rdy && r_mrs_pend)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // The wait counter is loaded on entry to each command state so the command cycle itself
  // counts toward tRP/tRFC/tMOD; the next command lands exactly T_x clocks later.
  always_ff @(posedge i_clock_t) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_wait  <= '0;
      r_cmd   <= CmdDes;
      r_addr  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_cmd  <= CmdDes;
          r_addr <= '0;
          if ((r_ref_pend || r_mrs_pend) && w_drained) begin
            r_state <= StPrea;
            r_wait  <= WaitW'(T_RP - 1);
            r_cmd   <= CmdPrea;
            r_addr  <= PreaAddr;
          end
        end
        StPrea: begin
          r_state <= StWaitRp;
          r_wait  <= r_wait - WaitW'(1);
          r_cmd   <= CmdDes;
          r_addr  <= '0;
        end
        StWaitRp: begin
          if (r_wait == '0) begin
            if (r_ref_pend) begin
              r_state <= StRef;
              r_wait  <= WaitW'(T_RFC - 1);
              r_cmd   <= CmdRef;
              r_addr  <= '0;
            end else begin
              r_state <= StMrs;
              r_wait  <= WaitW'(T_MOD - 1);
              r_cmd   <= CmdMrs;
              r_addr  <= r_mrs_op;
            end
          end else begin
            r_wait <= r_wait - WaitW'(1);
          end
        end
        StRef: begin
          r_state <= StWaitRfc;
          r_wait  <= r_wait - WaitW'(1);
          r_cmd   <= CmdDes;
          r_addr  <= '0;
        end
        StWaitRfc: begin
          if (r_wait == '0) begin
            if (r_mrs_pend) begin
              r_state <= StMrs;
              r_wait  <= WaitW'(T_MOD - 1);
              r_cmd   <= CmdMrs;
              r_addr  <= r_mrs_op;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_wait <= r_wait - WaitW'(1);
          end
        end
        StMrs: begin
          r_state <= StWaitMod;
          r_wait  <= r_wait - WaitW'(1);
          r_cmd   <= CmdDes;
          r_addr  <= '0;
        end
        StWaitMod: begin
          if (r_wait == '0) begin
            r_state <= StIdle;
          end else begin
            r_wait <= r_wait - WaitW'(1);
          end
        end
        default: begin
          r_state <= StIdle;
          r_wait  <= '0;
          r_cmd   <= CmdDes;
          r_addr  <= '0;
        end
      endcase
    end
  end

  assign io_bus.cs_n            = r_cmd[4];
  assign io_bus.act_n           = r_cmd[3];
  assign io_bus.ras_n           = r_cmd[2];
  assign io_bus.cas_n           = r_cmd[1];
  assign io_bus.we_n            = r_cmd[0];
  assign io_bus.bg              = 2'b00;
  assign io_bus.ba              = 2'b00;
  assign io_bus.addr            = r_addr;
  assign io_bus.maint_busy      = (r_state != StIdle);
  assign io_bus.maint_cmd_valid = (r_state != StIdle);
  assign io_bus.rw_idle         = w_drained && (r_state == StIdle);
  assign io_bus.req_overrun     = r_overrun;

`ifdef DDR_MAINT_STATS_EN
  logic [15:0] r_ref_count;
  logic [15:0] r_mrs_count;

  always_ff @(posedge i_clock_t) begin
    if (i_reset) begin
      r_ref_count <= '0;
      r_mrs_count <= '0;
    end else begin
      if (w_ref_clr) r_ref_count <= r_ref_count + 16'd1;
      if (w_mrs_clr) r_mrs_count <= r_mrs_count + 16'd1;
    end
  end

  assign o_ref_count = r_ref_count;
  assign o_mrs_count = r_mrs_count;
`endif

  // The controller must hold off RW grants until the maintenance sequence has finished.
  a_no_rw_grant_in_maint : assert property (
    @(posedge i_clock_t) disable iff (i_reset)
    (r_state != StIdle) |-> !$rose(io_bus.rw_proc)
  ) else $error("rw_proc rose during a maintenance sequence");

endmodule

// File: tb/tb_ddr_maint_cmd_issuer.sv
// Directed bench for ddr_maint_cmd_issuer: drain table plus PREA/REF/MRS timing sequences.
module tb_ddr_maint_cmd_issuer;
  localparam int unsigned MW = 18;
  localparam logic [4:0] CmdDes  = 5'b11111;
  localparam logic [4:0] CmdPrea = 5'b01010;
  localparam logic [4:0] CmdRef  = 5'b01001;
  localparam logic [4:0] CmdMrs  = 5'b01000;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ddr_maint_cmd_issuer_if #(.MRS_WIDTH(MW)) bus ();

`ifdef DDR_MAINT_STATS_EN
  logic [15:0] ref_count;
  logic [15:0] mrs_count;
`endif

  ddr_maint_cmd_issuer #(
    .MRS_WIDTH(MW),
    .T_RP     (13),
    .T_RFC    (260),
    .T_MOD    (24),
    .T_DRAIN  (16)
  ) dut (
    .i_clock_t  (clk),
    .i_reset    (rst),
    .io_bus     (bus)
`ifdef DDR_MAINT_STATS_EN
    ,
    .o_ref_count(ref_count),
    .o_mrs_count(mrs_count)
`endif
  );

  typedef struct packed {
    logic rw_proc;
    logic rw_active;
    logic exp_idle;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] cmd_now();
    return {bus.cs_n, bus.act_n, bus.ras_n, bus.cas_n, bus.we_n};
  endfunction

  task automatic chk_cmd(input string name, input logic [4:0] ec, input logic [MW-1:0] ea);
    chk({name, "_cmd"}, 32'(cmd_now()), 32'(ec));
    chk({name, "_addr"}, 32'(bus.addr), 32'(ea));
    chk({name, "_bgba"}, 32'({bus.bg, bus.ba}), 32'h0);
  endtask

  task automatic add_vec(input logic p, input logic a, input logic e, input int reps);
    vec_t v;
    v.rw_proc   = p;
    v.rw_active = a;
    v.exp_idle  = e;
    for (int i = 0; i < reps; i++) vecs.push_back(v);
  endtask

  task automatic pulse(input logic r, input logic m, input logic [MW-1:0] op);
    bus.refresh_rdy    = r;
    bus.mrs_update_rdy = m;
    bus.mrs_update_cmd = op;
    tick();
    bus.refresh_rdy    = 1'b0;
    bus.mrs_update_rdy = 1'b0;
    bus.mrs_update_cmd = '1;
  endtask

  // Clocks until the next non-DESELECT command, bounded by max.
  task automatic wait_cmd(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.cs_n && n < max);
  endtask

  // Clocks until maint_busy falls, counting any commands seen on the way.
  task automatic wait_idle(input int max, output int n, output int cmds);
    n    = 0;
    cmds = 0;
    do begin
      tick();
      n++;
      if (!bus.cs_n) cmds++;
    end while (bus.maint_busy && n < max);
  endtask

  initial begin
    int n;
    int cmds;
    int first_idle;
    int busy_seen;

    // Drain table: each row is one clock of rw_proc/rw_active with the expected rw_idle.
    add_vec(1'b0, 1'b0, 1'b0, 15);
    add_vec(1'b0, 1'b0, 1'b1, 1);
    add_vec(1'b0, 1'b1, 1'b0, 1);
    add_vec(1'b0, 1'b0, 1'b0, 15);
    add_vec(1'b0, 1'b0, 1'b1, 3);
    add_vec(1'b1, 1'b0, 1'b0, 1);
    add_vec(1'b1, 1'b1, 1'b0, 1);
    add_vec(1'b0, 1'b0, 1'b0, 15);
    add_vec(1'b0, 1'b0, 1'b1, 2);

    rst                = 1'b1;
    bus.rw_proc        = 1'b1;
    bus.rw_active      = 1'b0;
    bus.refresh_rdy    = 1'b0;
    bus.mrs_update_rdy = 1'b0;
    bus.mrs_update_cmd = '0;
    repeat (3) tick();

    chk_cmd("reset", CmdDes, '0);
    chk("reset_rw_idle", 32'(bus.rw_idle), 32'h0);
    chk("reset_busy", 32'(bus.maint_busy), 32'h0);
    chk("reset_valid", 32'(bus.maint_cmd_valid), 32'h0);
    chk("reset_overrun", 32'(bus.req_overrun), 32'h0);
`ifdef DDR_MAINT_STATS_EN
    chk("reset_ref_count", 32'(ref_count), 32'h0);
    chk("reset_mrs_count", 32'(mrs_count), 32'h0);
`endif

    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.rw_proc   = vecs[i].rw_proc;
      bus.rw_active = vecs[i].rw_active;
      tick();
      chk($sformatf("vec%0d_rw_idle", i), 32'(bus.rw_idle), 32'(vecs[i].exp_idle));
      chk($sformatf("vec%0d_cs_n", i), 32'(bus.cs_n), 32'h1);
      chk($sformatf("vec%0d_busy", i), 32'(bus.maint_busy), 32'h0);
    end
    bus.rw_proc   = 1'b0;
    bus.rw_active = 1'b0;

    // Refresh only.
    pulse(1'b1, 1'b0, '0);
    chk("ref_busy_n", 32'(bus.maint_busy), 32'h0);
    tick();
    chk_cmd("ref_prea", CmdPrea, 18'h00400);
    chk("ref_prea_valid", 32'(bus.maint_cmd_valid), 32'h1);
    chk("ref_prea_rw_idle", 32'(bus.rw_idle), 32'h0);
    wait_cmd(40, n);
    chk("ref_trp", 32'(n), 32'd13);
    chk_cmd("ref_ref", CmdRef, '0);
    wait_idle(400, n, cmds);
    chk("ref_trfc", 32'(n), 32'd260);
    chk("ref_trfc_cmds", 32'(cmds), 32'd0);
    chk("ref_done_rw_idle", 32'(bus.rw_idle), 32'h1);
    chk("ref_done_valid", 32'(bus.maint_cmd_valid), 32'h0);

    // MRS only; opcode must be the one present with the pulse.
    pulse(1'b0, 1'b1, 18'h00A01);
    tick();
    chk_cmd("mrs_prea", CmdPrea, 18'h00400);
    wait_cmd(40, n);
    chk("mrs_trp", 32'(n), 32'd13);
    chk_cmd("mrs_mrs", CmdMrs, 18'h00A01);
    wait_idle(100, n, cmds);
    chk("mrs_tmod", 32'(n), 32'd24);
    chk("mrs_tmod_cmds", 32'(cmds), 32'd0);
    chk("mrs_done_rw_idle", 32'(bus.rw_idle), 32'h1);

    // Both in the same cycle: one PREA, REF first, MRS tRFC later.
    pulse(1'b1, 1'b1, 18'h2B34C);
    tick();
    chk_cmd("both_prea", CmdPrea, 18'h00400);
    wait_cmd(40, n);
    chk("both_trp", 32'(n), 32'd13);
    chk_cmd("both_ref", CmdRef, '0);
    wait_cmd(400, n);
    chk("both_trfc", 32'(n), 32'd260);
    chk_cmd("both_mrs", CmdMrs, 18'h2B34C);
    wait_idle(100, n, cmds);
    chk("both_tmod", 32'(n), 32'd24);
    chk("both_overrun", 32'(bus.req_overrun), 32'h0);
`ifdef DDR_MAINT_STATS_EN
    chk("both_ref_count", 32'(ref_count), 32'd2);
    chk("both_mrs_count", 32'(mrs_count), 32'd2);
`endif

    // Repeat refresh while pending: sticky overrun, single REF.
    pulse(1'b1, 1'b0, '0);
    pulse(1'b1, 1'b0, '0);
    chk("ovr_flag", 32'(bus.req_overrun), 32'h1);
    chk_cmd("ovr_prea", CmdPrea, 18'h00400);
    wait_cmd(40, n);
    chk("ovr_trp", 32'(n), 32'd13);
    chk_cmd("ovr_ref", CmdRef, '0);
    wait_idle(400, n, cmds);
    chk("ovr_trfc", 32'(n), 32'd260);
    cmds = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!bus.cs_n || bus.maint_busy) cmds++;
    end
    chk("ovr_no_second_ref", 32'(cmds), 32'd0);
    chk("ovr_sticky", 32'(bus.req_overrun), 32'h1);
`ifdef DDR_MAINT_STATS_EN
    chk("ovr_ref_count", 32'(ref_count), 32'd3);
`endif

    // Reset during WAIT_RFC with MRS still pending.
    pulse(1'b1, 1'b1, 18'h00123);
    tick();
    chk_cmd("rst_prea", CmdPrea, 18'h00400);
    wait_cmd(40, n);
    chk_cmd("rst_ref", CmdRef, '0);
    repeat (50) tick();
    chk("rst_in_rfc_busy", 32'(bus.maint_busy), 32'h1);
    rst = 1'b1;
    tick();
    chk_cmd("rst_mid", CmdDes, '0);
    chk("rst_mid_busy", 32'(bus.maint_busy), 32'h0);
    chk("rst_mid_valid", 32'(bus.maint_cmd_valid), 32'h0);
    chk("rst_mid_rw_idle", 32'(bus.rw_idle), 32'h0);
    chk("rst_mid_overrun", 32'(bus.req_overrun), 32'h0);
`ifdef DDR_MAINT_STATS_EN
    chk("rst_mid_ref_count", 32'(ref_count), 32'h0);
    chk("rst_mid_mrs_count", 32'(mrs_count), 32'h0);
`endif
    rst        = 1'b0;
    first_idle = 0;
    cmds       = 0;
    busy_seen  = 0;
    for (int i = 1; i <= 320; i++) begin
      tick();
      if (bus.rw_idle && first_idle == 0) first_idle = i;
      if (!bus.cs_n) cmds++;
      if (bus.maint_busy) busy_seen++;
    end
    chk("rst_redrain", 32'(first_idle), 32'd16);
    chk("rst_no_mrs", 32'(cmds), 32'd0);
    chk("rst_no_busy", 32'(busy_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
